// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the producer-side handshake and the FIFO write-side signals of
//   fifo_wr_arbiter into one interface.
//
// Parameters
//   N_REQ   number of producers
//   DATA_W  word width (matches the FIFO write word)
//
// Signals
//   req_valid    [N_REQ]         per-producer word valid
//   req_data     [N_REQ*DATA_W]  producer i word at [i*DATA_W +: DATA_W]
//   req_ready    [N_REQ]         per-producer accept strobe
//   fifo_full                    FIFO full flag
//   fifo_wr_en                   FIFO write strobe
//   fifo_wr_data [DATA_W]        FIFO write word
//   grant_id     [clog2(N_REQ)]  current / last granted producer
//   busy                         high while a burst is in progress
//
// Modports
//   master : the producers plus the FIFO (drives requests and full flag)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_wr_data;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;

    modport master (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_wr_data,
        input  grant_id,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_wr_data,
        output grant_id,
        output busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the single write port of a FIFO among N_REQ producers using
//   round-robin arbitration with burst locking. A granted producer owns the
//   port for up to MAX_BURST accepted words, or until it drops valid, and
//   then the port goes back through one arbitration cycle.
//
// Parameters
//   N_REQ      number of producers (2..8)
//   DATA_W     word width, equal to the FIFO write word
//   MAX_BURST  maximum words accepted per grant (1..255)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bus         fifo_wr_arbiter_if.slave (producer handshake + FIFO write side)
//   stat_words  [N_REQ*16] per-producer accepted-word counters
//               (present only when ARB_STATS_EN is defined)
//
// Optional feature macro: ARB_STATS_EN
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_wr_arbiter_if.slave      bus
`ifdef ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]   stat_words
`endif
);

    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SCAN_W = ID_W + 1;
    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic              busy_q, busy_d;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [SCAN_W-1:0] scan_idx;

    logic              in_burst;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              accept;
    logic [N_REQ-1:0]  req_ready_c;

    // Round-robin pick: scan rr_ptr+1, rr_ptr+2, ... wrapping at N_REQ.
    // The sum is one bit wider so the wrap needs only a single subtract.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + SCAN_W'(k);
            if (scan_idx >= SCAN_W'(N_REQ)) begin
                scan_idx = scan_idx - SCAN_W'(N_REQ);
            end
            if (!pick_found && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    // Select the granted producer's valid and data word.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_burst = (state_q == BURST);
    assign accept   = in_burst && sel_valid && !bus.fifo_full;

    // Only the granted producer sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (in_burst && !bus.fifo_full && (grant_id_q == ID_W'(i))) begin
                req_ready_c[i] = 1'b1;
            end
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.fifo_wr_en   = accept;
    assign bus.fifo_wr_data = in_burst ? sel_data : '0;
    assign bus.grant_id     = grant_id_q;
    assign bus.busy         = busy_q;

    // Next-state logic. A granted producer dropping valid releases the port
    // even while the FIFO is full, since it has nothing left to send.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = BURST;
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                    busy_d      = 1'b1;
                end
            end
            BURST: begin
                if (!sel_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_id_q;
                    busy_d   = 1'b0;
                end else if (accept) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    if (burst_cnt_q == LAST_CNT) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_id_q;
                        busy_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM and registered outputs. rr_ptr resets to the last producer so
    // that producer 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= ID_W'(N_REQ - 1);
            burst_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            busy_q      <= busy_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stat_q [N_REQ];
    logic [15:0] stat_d [N_REQ];

    // Per-producer accepted-word counters; 16-bit wrap is intentional.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            stat_d[i] = stat_q[i];
            if (accept && (grant_id_q == ID_W'(i))) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    always_comb begin
        stat_words = '0;
        for (int i = 0; i < N_REQ; i++) begin
            stat_words[i*16 +: 16] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Testbench for fifo_wr_arbiter (N_REQ=4, DATA_W=16, MAX_BURST=8).
//   A transaction-level reference model (current owner, words taken in the
//   current grant, last finished owner) predicts every cycle's outputs.
//   Directed scenarios are followed by a randomized phase.
//   Build with ARB_STATS_EN defined to also cover the stat_words counters.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

`ifdef ARB_STATS_EN
    logic [N*16-1:0] stat_words;
`endif

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ARB_STATS_EN
        ,
        .stat_words (stat_words)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int mOwner;
    int mTaken;
    int mGrant;
    int mRrLast;
    int mStat [N];

    // Observations of the DUT
    int obsWr;
    int obsWrBy [N];
    int obsReady3;
    logic obsPrevBusy;
    int obsGrantSeq [$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mOwner  = -1;
        mTaken  = 0;
        mGrant  = 0;
        mRrLast = N - 1;
        for (int i = 0; i < N; i++) mStat[i] = 0;
    endtask

    // Called at a falling edge: drive one cycle, check outputs, advance model.
    task automatic applyStimulus(input logic [N-1:0] v, input logic f);
        logic [N-1:0]  expReady;
        logic          expWr;
        logic [DW-1:0] expData;
        bus.req_valid = v;
        bus.fifo_full = f;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = DW'($urandom);
        #1;
        expReady = '0;
        expWr    = 1'b0;
        expData  = '0;
        if (mOwner >= 0) begin
            if (!f) expReady[mOwner] = 1'b1;
            expWr   = v[mOwner] && !f;
            expData = bus.req_data[mOwner*DW +: DW];
        end
        checkOutput("busy",      32'(bus.busy),         32'(mOwner >= 0));
        checkOutput("grant_id",  32'(bus.grant_id),     32'(mGrant));
        checkOutput("req_ready", 32'(bus.req_ready),    32'(expReady));
        checkOutput("wr_en",     32'(bus.fifo_wr_en),   32'(expWr));
        checkOutput("wr_data",   32'(bus.fifo_wr_data), 32'(expData));

        if (bus.fifo_wr_en) begin
            obsWr++;
            obsWrBy[bus.grant_id]++;
        end
        if (bus.req_ready[3]) obsReady3++;
        if (bus.busy && !obsPrevBusy) obsGrantSeq.push_back(int'(bus.grant_id));
        obsPrevBusy = bus.busy;

        if (mOwner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mRrLast + k) % N;
                if (mOwner < 0 && v[c]) begin
                    mOwner = c;
                    mGrant = c;
                    mTaken = 0;
                end
            end
        end else if (!v[mOwner]) begin
            mRrLast = mOwner;
            mOwner  = -1;
        end else if (!f) begin
            mStat[mOwner] = (mStat[mOwner] + 1) % 65536;
            mTaken++;
            if (mTaken == MB) begin
                mRrLast = mOwner;
                mOwner  = -1;
            end
        end
        @(negedge clk);
    endtask

    // Assert reset at a falling edge while inputs keep requesting.
    task automatic resetMidBurst();
        bus.req_valid = '1;
        bus.fifo_full = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy",  32'(bus.busy),         32'd0);
        checkOutput("rst_wr_en", 32'(bus.fifo_wr_en),   32'd0);
        checkOutput("rst_grant", 32'(bus.grant_id),     32'd0);
        checkOutput("rst_ready", 32'(bus.req_ready),    32'd0);
        checkOutput("rst_data",  32'(bus.fifo_wr_data), 32'd0);
        modelReset();
        obsPrevBusy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.fifo_full = 1'b0;
        bus.req_data  = '0;
        obsWr         = 0;
        obsReady3     = 0;
        obsPrevBusy   = 1'b0;
        for (int i = 0; i < N; i++) obsWrBy[i] = 0;
        modelReset();
        #1;
        checkOutput("reset_busy",  32'(bus.busy),       32'd0);
        checkOutput("reset_grant", 32'(bus.grant_id),   32'd0);
        checkOutput("reset_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        checkOutput("reset_ready", 32'(bus.req_ready),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All producers valid: grants 0,1,2,3,0 with 8 words each, one idle cycle apart.
        $display("[TB] all-valid round robin");
        base = obsWr;
        obsGrantSeq.delete();
        repeat (45) applyStimulus('1, 1'b0);
        checkOutput("rr_words", 32'(obsWr - base), 32'd40);
        checkOutput("rr_bursts", 32'(obsGrantSeq.size()), 32'd5);
        for (int i = 0; i < 5 && i < obsGrantSeq.size(); i++) begin
            checkOutput("rr_grant_order", 32'(obsGrantSeq[i]), 32'(i % N));
        end

        // Producer 2 alone: 3 words then drops valid.
        $display("[TB] producer 2 short burst");
        base = obsWrBy[2];
        repeat (4) applyStimulus(4'b0100, 1'b0);
        repeat (2) applyStimulus(4'b0000, 1'b0);
        checkOutput("p2_words", 32'(obsWrBy[2] - base), 32'd3);
        checkOutput("p2_grant", 32'(bus.grant_id), 32'd2);
        checkOutput("p2_idle",  32'(bus.busy), 32'd0);

        // FIFO full for 5 cycles inside a producer 0 burst.
        $display("[TB] fifo full stall");
        base = obsWrBy[0];
        repeat (3) applyStimulus(4'b0001, 1'b0);
        begin
            int stallBase;
            stallBase = obsWr;
            repeat (5) applyStimulus(4'b0001, 1'b1);
            checkOutput("stall_words", 32'(obsWr - stallBase), 32'd0);
        end
        repeat (6) applyStimulus(4'b0001, 1'b0);
        checkOutput("stall_total", 32'(obsWrBy[0] - base), 32'd8);
        checkOutput("stall_done",  32'(bus.busy), 32'd0);
        applyStimulus(4'b0000, 1'b0);

        // Producer 3 requests during a producer 1 burst and goes next.
        $display("[TB] mid-burst request waits");
        applyStimulus(4'b0010, 1'b0);
        obsReady3 = 0;
        base = obsWrBy[1];
        repeat (8) applyStimulus(4'b1010, 1'b0);
        checkOutput("p1_words",  32'(obsWrBy[1] - base), 32'd8);
        checkOutput("p3_waited", 32'(obsReady3), 32'd0);
        applyStimulus(4'b1010, 1'b0);
        checkOutput("p3_next",   32'(bus.grant_id), 32'd3);
        checkOutput("p3_busy",   32'(bus.busy), 32'd1);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // Reset in the middle of a burst.
        $display("[TB] reset mid-burst");
        repeat (3) applyStimulus('1, 1'b0);
        resetMidBurst();

`ifdef ARB_STATS_EN
        // 20 words from producer 0 and 7 from producer 1 after reset.
        $display("[TB] statistics counters");
        for (int c = 0; c < 200 && mStat[0] < 20; c++) applyStimulus(4'b0001, 1'b0);
        repeat (2) applyStimulus(4'b0000, 1'b0);
        for (int c = 0; c < 200 && mStat[1] < 7; c++) applyStimulus(4'b0010, 1'b0);
        repeat (2) applyStimulus(4'b0000, 1'b0);
        checkOutput("stat_p0", 32'(stat_words[15:0]),  32'd20);
        checkOutput("stat_p1", 32'(stat_words[31:16]), 32'd7);
`endif

        // Randomized traffic with occasional full and valid churn.
        $display("[TB] random traffic");
        for (int c = 0; c < 800; c++) begin
            logic [N-1:0] v;
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 7);
            applyStimulus(v, $urandom_range(0, 9) < 2);
        end

`ifdef ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            checkOutput("stat_final", 32'(stat_words[i*16 +: 16]), 32'(mStat[i]));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
